// File: rtl/alu_writeback_unit_if.sv
// Request/write-back bundle between the ALU write-back stage and its driver.
interface alu_writeback_unit_if #(
  parameter int WIDTH = 18,
  parameter int AW    = 4
);
  logic             start;
  logic [2:0]       opcode;
  logic [AW-1:0]    dest;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic [AW-1:0]    wr;
  logic             we;
  logic [WIDTH-1:0] wb_data;
  logic             carry;
  logic             zero;

  modport slave (
    input  start, opcode, dest, op_a, op_b,
    output busy, wr, we, wb_data, carry, zero
  );

  modport master (
    output start, opcode, dest, op_a, op_b,
    input  busy, wr, we, wb_data, carry, zero
  );
endinterface

// File: rtl/alu_writeback_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus an 18-step shift-add multiply,
// each ending in a one-cycle register-file write.
// state | meaning
// IDLE  | waiting for start, busy=0
// EXEC  | single-cycle op, result registered on next edge
// MUL   | one multiplier bit per edge, LSB first
// WB    | we=1 for this cycle only
module alu_writeback_unit #(
  parameter int WIDTH = 18,
  parameter int AW    = 4
) (
  input logic                clk,
  input logic                reset,
  alu_writeback_unit_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  state_t             state_q;
  logic [2:0]         opc_q;
  logic [AW-1:0]      dest_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [4:0]         cnt_q;
  logic               busy_q;
  logic               we_q;
  logic [AW-1:0]      wr_q;
  logic [WIDTH-1:0]   wb_data_q;
  logic               carry_q;
  logic               zero_q;

  logic [WIDTH:0]     ext;
  logic [4:0]         amt;
  logic [WIDTH-1:0]   res_d;
  logic               cy_d;
  logic [2*WIDTH-1:0] prod_d;

  always_comb begin
    res_d = '0;
    cy_d  = 1'b0;
    ext   = '0;
    amt   = b_q[4:0];
    unique case (opc_q)
      OP_ADD: begin
        ext   = {1'b0, a_q} + {1'b0, b_q};
        res_d = ext[WIDTH-1:0];
        cy_d  = ext[WIDTH];
      end
      OP_SUB: begin
        // bit WIDTH of the widened difference is the borrow (a < b)
        ext   = {1'b0, a_q} - {1'b0, b_q};
        res_d = ext[WIDTH-1:0];
        cy_d  = ext[WIDTH];
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SHL: begin
        ext = {1'b0, a_q} << amt;
        if (amt < 5'(WIDTH)) begin
          res_d = ext[WIDTH-1:0];
          cy_d  = ext[WIDTH];
        end
      end
      OP_SHR: begin
        // guard bit below the LSB catches the last bit shifted out
        ext = {a_q, 1'b0} >> amt;
        if (amt < 5'(WIDTH)) begin
          res_d = ext[WIDTH:1];
          cy_d  = ext[0];
        end
      end
      OP_MUL: res_d = '0;
    endcase
  end

  assign prod_d = acc_q + (b_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_q      <= '0;
      wb_data_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            opc_q   <= bus.opcode;
            dest_q  <= bus.dest;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            mcand_q <= {{WIDTH{1'b0}}, bus.op_a};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          wb_data_q <= res_d;
          carry_q   <= cy_d;
          zero_q    <= (res_d == '0);
          wr_q      <= dest_q;
          we_q      <= 1'b1;
          state_q   <= S_WB;
        end
        S_MUL: begin
          acc_q   <= prod_d;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'(WIDTH - 1)) begin
            wb_data_q <= prod_d[WIDTH-1:0];
            carry_q   <= |prod_d[2*WIDTH-1:WIDTH];
            zero_q    <= (prod_d[WIDTH-1:0] == '0);
            wr_q      <= dest_q;
            we_q      <= 1'b1;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.we      = we_q;
  assign bus.wr      = wr_q;
  assign bus.wb_data = wb_data_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;
endmodule

// File: tb/tb_alu_writeback_unit.sv
// Scoreboard bench for alu_writeback_unit: driver pushes reference results on acceptance,
// a negedge monitor pops and compares each register-file write.
module tb_alu_writeback_unit;
  localparam int W  = 18;
  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] dest;
    logic [W-1:0]  res;
    logic          cy;
    logic          z;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_writeback_unit_if #(.WIDTH(W), .AW(AW)) bus ();
  alu_writeback_unit #(.WIDTH(W), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t          sb[$];
  exp_t          me;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            writes = 0;
  logic [W-1:0]  held_data = '0;
  logic [AW-1:0] held_wr = '0;
  logic          held_cy = 1'b0;
  logic          held_z = 1'b0;
  logic          prev_we = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic rules, using wide integers.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c);
    longint la = longint'(a);
    longint lb = longint'(b);
    longint m  = 64'd262144;
    longint p;
    int     amt = int'(b[4:0]);
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin p = la + lb; r = W'(p % m); c = (p >= m); end
      3'd1: begin r = W'((la - lb + m) % m); c = (la < lb); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: if (amt > 0 && amt < 18) begin
              r = W'((la << amt) % m);
              c = ((la >> (18 - amt)) & 1) != 0;
            end else if (amt == 0) r = a;
      3'd6: if (amt > 0 && amt < 18) begin
              r = W'(la >> amt);
              c = ((la >> (amt - 1)) & 1) != 0;
            end else if (amt == 0) r = a;
      default: begin p = la * lb; r = W'(p % m); c = (p >= m); end
    endcase
  endtask

  // One cycle of stimulus; a request presented while busy is low will be taken on the next edge.
  task automatic step(input logic st, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [AW-1:0] d);
    exp_t         e;
    logic [W-1:0] r;
    logic         c;
    @(negedge clk);
    bus.start = st; bus.opcode = op; bus.op_a = a; bus.op_b = b; bus.dest = d;
    if (st && reset && bus.busy === 1'b0) begin
      model(op, a, b, r, c);
      e.dest = d; e.res = r; e.cy = c; e.z = (r == '0);
      e.due  = cyc + 1 + ((op == 3'd7) ? 18 : 1);
      sb.push_back(e);
    end
  endtask

  task automatic step_idle();
    step(1'b0, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), AW'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d);
    wait_idle();
    step(1'b1, op, a, b, d);
    step_idle();
    chk("busy_after_start", bus.busy, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.we === 1'b1) begin
        chk("we_no_merge", prev_we, 1'b0);
        chk("busy_during_we", bus.busy, 1'b1);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_we: wr=%0d data=%0h, required no write", bus.wr, bus.wb_data);
        end else begin
          me = sb.pop_front();
          chk("we_latency", 64'(cyc), 64'(me.due));
          chk("wr", bus.wr, me.dest);
          chk("wb_data", bus.wb_data, me.res);
          chk("carry", bus.carry, me.cy);
          chk("zero", bus.zero, me.z);
          held_data = me.res; held_wr = me.dest; held_cy = me.cy; held_z = me.z;
          writes++;
        end
      end else begin
        chk("hold_data", bus.wb_data, held_data);
        chk("hold_wr", bus.wr, held_wr);
        chk("hold_flags", {bus.carry, bus.zero}, {held_cy, held_z});
        if (prev_we) chk("busy_after_wb", bus.busy, 1'b0);
      end
      prev_we = bus.we;
    end
  end

  initial begin
    bus.start = 1'b0; bus.opcode = '0; bus.op_a = '0; bus.op_b = '0; bus.dest = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_we", bus.we, 1'b0);
    chk("reset_outputs", {bus.wr, bus.wb_data, bus.carry, bus.zero}, '0);
    reset = 1'b1;
    step_idle();

    issue(3'd0, 18'h3FFFF, 18'h00001, 4'd5);
    issue(3'd1, 18'd5, 18'd7, 4'd3);
    issue(3'd4, 18'h2AAAA, 18'h15555, 4'd7);
    issue(3'd5, 18'h00001, 18'd17, 4'd2);
    issue(3'd5, 18'h20001, 18'd1, 4'd4);
    issue(3'd6, 18'h00003, 18'd1, 4'd6);
    issue(3'd5, 18'h1F0F0, 18'd20, 4'd8);
    issue(3'd5, 18'h12345, 18'd18, 4'd9);
    issue(3'd6, 18'h2BCDE, 18'd0, 4'd10);
    issue(3'd2, 18'h3C3C3, 18'h0FF00, 4'd11);
    issue(3'd3, 18'h00000, 18'h00000, 4'd12);
    issue(3'd7, 18'd300, 18'd500, 4'd15);

    // an ADD request mid-multiply must be dropped
    issue(3'd7, 18'd1000, 18'd1000, 4'd13);
    repeat (4) step_idle();
    step(1'b1, 3'd0, 18'd1, 18'd1, 4'd14);
    step_idle();

    // reset five cycles into a multiply aborts it without a write
    issue(3'd7, 18'h3FFFF, 18'h3FFFF, 4'd1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_we", bus.we, 1'b0);
    chk("abort_outputs", {bus.wr, bus.wb_data, bus.carry, bus.zero}, '0);
    sb.delete();
    held_data = '0; held_wr = '0; held_cy = 1'b0; held_z = 1'b0; prev_we = 1'b0;
    repeat (3) step_idle();
    reset = 1'b1;
    repeat (25) step_idle();
    issue(3'd0, 18'd2, 18'd3, 4'd1);

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), AW'($urandom));
    // small operands make zero results and short shifts more likely
    for (int i = 0; i < 20; i++)
      issue(3'($urandom_range(0, 7)), W'($urandom_range(0, 3)), W'($urandom_range(0, 19)),
            AW'($urandom));

    // start held high: requests are taken back-to-back whenever busy drops
    for (int i = 0; i < 120; i++)
      step(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), AW'($urandom));
    step_idle();

    begin
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
        step_idle();
        n++;
      end
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) step_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
